// File: rtl/dice_rules_multi.sv
// N-player shooter/point dice game sequencer sitting between the dice roller
// and the score/display logic; every output is driven from a register.
module dice_rules_multi #(
   parameter int N_PLAYERS  = 4,
   parameter int NUM_W      = 5,
   parameter int WIN_A      = 5,
   parameter int WIN_B      = 11,
   parameter int MIN_SUM    = 2,
   parameter int MAX_SUM    = 12,
   parameter int MAX_ROUNDS = 15,
   parameter int RND_W      = 4,
   parameter int ROTATE     = 0,
   localparam int PW        = (N_PLAYERS > 2) ? $clog2(N_PLAYERS) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             roll_valid,
   input  logic [NUM_W-1:0] roll_sum,
   output logic             roll_req,
   output logic [PW-1:0]    cur_player,
   output logic [NUM_W-1:0] point,
   output logic             winner_valid,
   output logic [PW-1:0]    winner,
   output logic             timeout,
   output logic             game_over,
   output logic [RND_W-1:0] round_cnt,
   output logic             bad_roll,
   output logic             rng_en
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SHOOT = 3'd1,
      ST_GAP   = 3'd2,
      ST_OTHER = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t           state_r, state_s;
   logic [PW-1:0]    shooter_r, shooter_s, cur_player_r, cur_player_s;
   logic [PW-1:0]    winner_r, winner_s, rot_shooter_s;
   logic [NUM_W-1:0] point_r, point_s;
   logic [RND_W-1:0] round_cnt_r, round_cnt_s, rnd_inc_s;
   logic             winner_valid_r, winner_valid_s, timeout_r, timeout_s;
   logic             bad_roll_r, bad_roll_s;
   logic             roll_req_r, roll_req_s, game_over_r, game_over_s, rng_en_r, rng_en_s;
   logic             in_range_s, natural_s, limit_hit_s;

   function automatic logic [PW-1:0] next_player(input logic [PW-1:0] p);
      logic [PW-1:0] n;
      if (p == PW'(N_PLAYERS - 1)) n = {PW{1'b0}};
      else                         n = p + PW'(1);
      return n;
   endfunction

   assign in_range_s    = (roll_sum >= NUM_W'(MIN_SUM)) && (roll_sum <= NUM_W'(MAX_SUM));
   assign natural_s     = (roll_sum == NUM_W'(WIN_A)) || (roll_sum == NUM_W'(WIN_B));
   assign rnd_inc_s     = (round_cnt_r == {RND_W{1'b1}}) ? round_cnt_r : round_cnt_r + RND_W'(1);
   assign limit_hit_s   = (MAX_ROUNDS != 0) && (int'(rnd_inc_s) == MAX_ROUNDS);
   assign rot_shooter_s = (ROTATE != 0) ? next_player(shooter_r) : shooter_r;

   // State and output registers; reset abandons any game in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r        <= ST_IDLE;
         shooter_r      <= {PW{1'b0}};
         cur_player_r   <= {PW{1'b0}};
         point_r        <= {NUM_W{1'b0}};
         winner_r       <= {PW{1'b0}};
         winner_valid_r <= 1'b0;
         timeout_r      <= 1'b0;
         round_cnt_r    <= {RND_W{1'b0}};
         bad_roll_r     <= 1'b0;
         roll_req_r     <= 1'b0;
         game_over_r    <= 1'b0;
         rng_en_r       <= 1'b0;
      end else begin
         state_r        <= state_s;
         shooter_r      <= shooter_s;
         cur_player_r   <= cur_player_s;
         point_r        <= point_s;
         winner_r       <= winner_s;
         winner_valid_r <= winner_valid_s;
         timeout_r      <= timeout_s;
         round_cnt_r    <= round_cnt_s;
         bad_roll_r     <= bad_roll_s;
         roll_req_r     <= roll_req_s;
         game_over_r    <= game_over_s;
         rng_en_r       <= rng_en_s;
      end
   end

   // Next-state and game bookkeeping decided from the current roll.
   always_comb begin
      state_s        = state_r;
      shooter_s      = shooter_r;
      cur_player_s   = cur_player_r;
      point_s        = point_r;
      winner_s       = winner_r;
      winner_valid_s = winner_valid_r;
      timeout_s      = timeout_r;
      round_cnt_s    = round_cnt_r;
      bad_roll_s     = 1'b0;
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_s        = ST_SHOOT;
               shooter_s      = {PW{1'b0}};
               cur_player_s   = {PW{1'b0}};
               point_s        = {NUM_W{1'b0}};
               winner_s       = {PW{1'b0}};
               winner_valid_s = 1'b0;
               timeout_s      = 1'b0;
               round_cnt_s    = {RND_W{1'b0}};
            end else begin
               state_s = state_r;
            end
         end
         ST_SHOOT: begin
            if (roll_valid && in_range_s) begin
               if (natural_s) begin
                  state_s        = ST_DONE;
                  winner_s       = shooter_r;
                  winner_valid_s = 1'b1;
               end else begin
                  point_s      = roll_sum;
                  cur_player_s = next_player(shooter_r);
                  state_s      = ST_GAP;
               end
            end else begin
               bad_roll_s = roll_valid;
            end
         end
         ST_GAP: begin
            if (point_r != {NUM_W{1'b0}}) state_s = ST_OTHER;
            else                          state_s = ST_SHOOT;
         end
         ST_OTHER: begin
            if (roll_valid && in_range_s) begin
               if (roll_sum == point_r) begin
                  state_s        = ST_DONE;
                  winner_s       = shooter_r;
                  winner_valid_s = 1'b1;
               end else if (natural_s) begin
                  state_s        = ST_DONE;
                  winner_s       = cur_player_r;
                  winner_valid_s = 1'b1;
               end else if (next_player(cur_player_r) == shooter_r) begin
                  // everyone but the shooter has missed: close the round
                  round_cnt_s = rnd_inc_s;
                  point_s     = {NUM_W{1'b0}};
                  if (limit_hit_s) begin
                     state_s   = ST_DONE;
                     timeout_s = 1'b1;
                  end else begin
                     shooter_s    = rot_shooter_s;
                     cur_player_s = rot_shooter_s;
                     state_s      = ST_GAP;
                  end
               end else begin
                  cur_player_s = next_player(cur_player_r);
                  state_s      = ST_GAP;
               end
            end else begin
               bad_roll_s = roll_valid;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Output decode of the upcoming state, captured by the register block.
   always_comb begin
      roll_req_s  = 1'b0;
      game_over_s = 1'b0;
      rng_en_s    = 1'b0;
      case (state_s)
         ST_SHOOT, ST_OTHER: roll_req_s = 1'b1;
         ST_DONE: begin
            game_over_s = 1'b1;
            rng_en_s    = 1'b1;
         end
         default: roll_req_s = 1'b0;
      endcase
   end

   assign roll_req     = roll_req_r;
   assign cur_player   = cur_player_r;
   assign point        = point_r;
   assign winner_valid = winner_valid_r;
   assign winner       = winner_r;
   assign timeout      = timeout_r;
   assign game_over    = game_over_r;
   assign round_cnt    = round_cnt_r;
   assign bad_roll     = bad_roll_r;
   assign rng_en       = rng_en_r;

endmodule

// File: tb/tb_dice_rules_multi.sv
// Bench for dice_rules_multi: two configurations share stimulus and are checked
// every cycle against a game-level model, plus directed scenarios with literal values.
module tb_dice_rules_multi;

   localparam int P_IDLE = 0, P_ASK_SHOOTER = 1, P_GAP = 2, P_ASK_OTHER = 3, P_DONE = 4;

   typedef struct packed {
      int phase;
      int shooter;
      int asking;
      int point;
      int winner;
      int rounds;
      bit won;
      bit timed_out;
      bit bad;
   } mdl_t;

   logic       clk, rst, start, roll_valid;
   logic [4:0] roll_sum;

   logic       a_roll_req, a_winner_valid, a_timeout, a_game_over, a_bad_roll, a_rng_en;
   logic [1:0] a_cur_player, a_winner;
   logic [4:0] a_point;
   logic [2:0] a_round_cnt;
   logic       b_roll_req, b_winner_valid, b_timeout, b_game_over, b_bad_roll, b_rng_en;
   logic [1:0] b_cur_player, b_winner;
   logic [4:0] b_point;
   logic [3:0] b_round_cnt;

   int   errors = 0;
   int   checks = 0;
   bit   chk_en = 1'b0;
   mdl_t ma = '{default: 0};
   mdl_t mb = '{default: 0};

   // Three players, no round limit, fixed shooter, narrow round counter.
   dice_rules_multi #(.N_PLAYERS(3), .MAX_ROUNDS(0), .RND_W(3), .ROTATE(0)) dut_a (
      .clk(clk), .rst(rst), .start(start), .roll_valid(roll_valid), .roll_sum(roll_sum),
      .roll_req(a_roll_req), .cur_player(a_cur_player), .point(a_point),
      .winner_valid(a_winner_valid), .winner(a_winner), .timeout(a_timeout),
      .game_over(a_game_over), .round_cnt(a_round_cnt), .bad_roll(a_bad_roll), .rng_en(a_rng_en));

   // Four players, two-round limit, rotating shooter.
   dice_rules_multi #(.N_PLAYERS(4), .MAX_ROUNDS(2), .RND_W(4), .ROTATE(1)) dut_b (
      .clk(clk), .rst(rst), .start(start), .roll_valid(roll_valid), .roll_sum(roll_sum),
      .roll_req(b_roll_req), .cur_player(b_cur_player), .point(b_point),
      .winner_valid(b_winner_valid), .winner(b_winner), .timeout(b_timeout),
      .game_over(b_game_over), .round_cnt(b_round_cnt), .bad_roll(b_bad_roll), .rng_en(b_rng_en));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic mdl_t step(input mdl_t m, input bit r, input bit st, input bit v,
                                 input int s, input int n, input int lim, input int rmax,
                                 input bit rot);
      mdl_t x;
      x     = m;
      x.bad = 1'b0;
      if (r) begin
         x = '{default: 0};
      end else if (m.phase == P_IDLE || m.phase == P_DONE) begin
         if (st) begin
            x       = '{default: 0};
            x.phase = P_ASK_SHOOTER;
         end
      end else if (m.phase == P_GAP) begin
         x.phase = (m.point != 0) ? P_ASK_OTHER : P_ASK_SHOOTER;
      end else if (v && (s < 2 || s > 12)) begin
         x.bad = 1'b1;
      end else if (v && m.phase == P_ASK_SHOOTER) begin
         if (s == 5 || s == 11) begin
            x.phase = P_DONE; x.won = 1'b1; x.winner = m.shooter;
         end else begin
            x.point = s; x.asking = (m.shooter + 1) % n; x.phase = P_GAP;
         end
      end else if (v) begin
         if (s == m.point) begin
            x.phase = P_DONE; x.won = 1'b1; x.winner = m.shooter;
         end else if (s == 5 || s == 11) begin
            x.phase = P_DONE; x.won = 1'b1; x.winner = m.asking;
         end else if ((m.asking + 1) % n == m.shooter) begin
            x.rounds = (m.rounds < rmax) ? m.rounds + 1 : rmax;
            x.point  = 0;
            if (lim != 0 && x.rounds == lim) begin
               x.phase = P_DONE; x.timed_out = 1'b1;
            end else begin
               x.shooter = rot ? (m.shooter + 1) % n : m.shooter;
               x.asking  = x.shooter;
               x.phase   = P_GAP;
            end
         end else begin
            x.asking = (m.asking + 1) % n; x.phase = P_GAP;
         end
      end
      return x;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp(input string t, input mdl_t m, input int rr, input int cp, input int pt,
                      input int wv, input int w, input int to, input int go, input int rc,
                      input int br, input int re);
      chk({t, ".roll_req"}, rr, (m.phase == P_ASK_SHOOTER || m.phase == P_ASK_OTHER) ? 1 : 0);
      chk({t, ".cur_player"}, cp, m.asking);
      chk({t, ".point"}, pt, m.point);
      chk({t, ".winner_valid"}, wv, int'(m.won));
      chk({t, ".winner"}, w, m.winner);
      chk({t, ".timeout"}, to, int'(m.timed_out));
      chk({t, ".game_over"}, go, (m.phase == P_DONE) ? 1 : 0);
      chk({t, ".round_cnt"}, rc, m.rounds);
      chk({t, ".bad_roll"}, br, int'(m.bad));
      chk({t, ".rng_en"}, re, (m.phase == P_DONE) ? 1 : 0);
   endtask

   always @(posedge clk) begin
      ma <= step(ma, rst, start, roll_valid, int'(roll_sum), 3, 0, 7, 1'b0);
      mb <= step(mb, rst, start, roll_valid, int'(roll_sum), 4, 2, 15, 1'b1);
   end

   always @(negedge clk) begin
      if (chk_en) begin
         cmp("a", ma, int'(a_roll_req), int'(a_cur_player), int'(a_point), int'(a_winner_valid),
             int'(a_winner), int'(a_timeout), int'(a_game_over), int'(a_round_cnt),
             int'(a_bad_roll), int'(a_rng_en));
         cmp("b", mb, int'(b_roll_req), int'(b_cur_player), int'(b_point), int'(b_winner_valid),
             int'(b_winner), int'(b_timeout), int'(b_game_over), int'(b_round_cnt),
             int'(b_bad_roll), int'(b_rng_en));
      end
   end

   task automatic tick(input bit r, input bit st, input bit v, input int s);
      rst = r; start = st; roll_valid = v; roll_sum = 5'(s);
      @(negedge clk);
   endtask

   task automatic roll(input int s);
      tick(1'b0, 1'b0, 1'b1, s);
   endtask

   task automatic gap();
      tick(1'b0, 1'b0, 1'b0, 0);
   endtask

   // Full round in dut_b with nobody scoring: shooter sets 4, the others roll 3.
   task automatic dull_round();
      roll(4); gap();
      for (int k = 0; k < 3; k++) begin
         roll(3); gap();
      end
   endtask

   initial begin
      bit r, st, v;
      int s;
      rst = 1'b1; start = 1'b0; roll_valid = 1'b0; roll_sum = 5'd0;
      @(negedge clk);
      tick(1'b1, 1'b0, 1'b0, 0);
      chk_en = 1'b1;
      chk("rst.roll_req", int'(b_roll_req), 0);
      chk("rst.game_over", int'(b_game_over), 0);
      chk("rst.winner_valid", int'(b_winner_valid), 0);
      chk("rst.rng_en", int'(b_rng_en), 0);

      // shooter natural
      tick(1'b0, 1'b1, 1'b0, 0);
      chk("nat.req", int'(b_roll_req), 1);
      roll(11);
      chk("nat.winner_valid", int'(b_winner_valid), 1);
      chk("nat.winner", int'(b_winner), 0);
      chk("nat.game_over", int'(b_game_over), 1);
      chk("nat.rng_en", int'(b_rng_en), 1);
      chk("nat.req_low", int'(b_roll_req), 0);
      chk("nat.model_won", int'(mb.won), 1);
      roll(5);
      chk("done.sticky", int'(b_winner_valid), 1);

      // restart from DONE with a coincident roll, then point match
      tick(1'b0, 1'b1, 1'b1, 5);
      chk("restart.round_cnt", int'(b_round_cnt), 0);
      chk("restart.winner_valid", int'(b_winner_valid), 0);
      chk("restart.req", int'(b_roll_req), 1);
      chk("restart.cur", int'(b_cur_player), 0);
      roll(6);
      chk("pt.point", int'(b_point), 6);
      chk("pt.gap_req", int'(b_roll_req), 0);
      chk("pt.gap_cur", int'(b_cur_player), 1);
      gap();
      chk("pt.p1_req", int'(b_roll_req), 1);
      roll(8);
      chk("pt.p2_cur", int'(b_cur_player), 2);
      roll(5);
      chk("gapign.req", int'(b_roll_req), 1);
      chk("gapign.winner_valid", int'(b_winner_valid), 0);
      chk("gapign.bad", int'(b_bad_roll), 0);
      roll(6);
      chk("pt.winner_valid", int'(b_winner_valid), 1);
      chk("pt.winner", int'(b_winner), 0);

      // non-shooter natural
      tick(1'b0, 1'b1, 1'b0, 0);
      roll(4); gap(); roll(5);
      chk("other.winner", int'(b_winner), 1);
      chk("other.point", int'(b_point), 4);
      chk("other.model_winner", mb.winner, 1);

      // two dull rounds hit the round limit
      tick(1'b0, 1'b1, 1'b0, 0);
      dull_round();
      chk("to.round1", int'(b_round_cnt), 1);
      chk("to.rot_cur", int'(b_cur_player), 1);
      roll(4); gap(); roll(3); gap(); roll(3); gap();
      chk("to.last_cur", int'(b_cur_player), 0);
      roll(3);
      chk("to.timeout", int'(b_timeout), 1);
      chk("to.winner_valid", int'(b_winner_valid), 0);
      chk("to.round_cnt", int'(b_round_cnt), 2);
      chk("to.model_rounds", mb.rounds, 2);

      // rotation: second shooter wins on p0's point roll
      tick(1'b0, 1'b1, 1'b0, 0);
      dull_round();
      chk("rot.cur1", int'(b_cur_player), 1);
      roll(4); gap();
      chk("rot.cur2", int'(b_cur_player), 2);
      roll(3); gap();
      chk("rot.cur3", int'(b_cur_player), 3);
      roll(3); gap();
      chk("rot.cur0", int'(b_cur_player), 0);
      roll(4);
      chk("rot.winner", int'(b_winner), 1);
      chk("rot.winner_valid", int'(b_winner_valid), 1);

      // out-of-range sums
      tick(1'b0, 1'b1, 1'b0, 0);
      roll(13);
      chk("bad13.pulse", int'(b_bad_roll), 1);
      chk("bad13.req", int'(b_roll_req), 1);
      roll(0);
      chk("bad0.pulse", int'(b_bad_roll), 1);
      chk("bad0.point", int'(b_point), 0);
      gap();
      chk("bad.clear", int'(b_bad_roll), 0);

      // reset while a non-shooter is being asked
      roll(6); gap();
      tick(1'b1, 1'b0, 1'b0, 0);
      chk("rstmid.req", int'(b_roll_req), 0);
      chk("rstmid.point", int'(b_point), 0);
      chk("rstmid.cur", int'(b_cur_player), 0);

      for (int i = 0; i < 4000; i++) begin
         r  = ($urandom_range(0, 299) == 0);
         st = (ma.phase == P_DONE || mb.phase == P_DONE || ma.phase == P_IDLE) ?
              ($urandom_range(0, 3) == 0) : ($urandom_range(0, 59) == 0);
         v  = ($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 9) == 0)
            s = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 1)) : int'($urandom_range(13, 31));
         else
            s = int'($urandom_range(2, 12));
         tick(r, st, v, s);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
